// File: rtl/freq_div_pkg.sv
// Shared constants for the programmable frequency divider: FSM encoding and
// the smallest legal divide ratio.
package freq_div_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/div_shadow_ctrl.sv
// Divisor shadow register: captures and clamps load requests, holds the
// pending flag, and promotes the shadow to the active divisor on apply.
module div_shadow_ctrl
  import freq_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             apply,
  output logic [WIDTH-1:0] active_div,
  output logic [WIDTH-1:0] active_next,
  output logic             div_pending,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] shadow;
  logic             too_small;

  assign too_small = div_in < MIN_W;

  // The top decodes its registered outputs from this, so the divisor in
  // effect after the edge is visible in the same cycle as the wrap.
  assign active_next = (apply && div_pending) ? shadow : active_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= DEF_W;
      active_div  <= DEF_W;
      div_pending <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      active_div <= active_next;
      div_err    <= div_load && too_small;
      if (div_load) begin
        shadow      <= too_small ? MIN_W : div_in;
        div_pending <= 1'b1;
      end else if (apply) begin
        div_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_freq_divider.sv
// Programmable clock divider: IDLE/RUN FSM, period counter and registered
// freq_out/tick decode; divisor changes take effect only at period boundaries.
module prog_freq_divider
  import freq_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             freq_in,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             freq_out,
  output logic             tick,
  output logic             div_pending,
  output logic             div_err
);

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] active_div, active_next;
  logic             wrap, apply;
  logic             freq_d, tick_d;

  assign wrap  = (state == RUN) && (cnt == active_div - WIDTH'(1));
  assign apply = (state == IDLE) || wrap;

  div_shadow_ctrl #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_shadow (
    .clk        (freq_in),
    .rst        (rst),
    .div_in     (div_in),
    .div_load   (div_load),
    .apply      (apply),
    .active_div (active_div),
    .active_next(active_next),
    .div_pending(div_pending),
    .div_err    (div_err)
  );

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      IDLE: if (en) state_next = RUN;
      RUN: begin
        if (!en)       state_next = IDLE;
        else if (!wrap) cnt_next  = cnt + WIDTH'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they line up with cnt.
  assign freq_d = (state_next == RUN) && (cnt_next < (active_next >> 1));
  assign tick_d = (state_next == RUN) && (cnt_next == '0);

  always_ff @(posedge freq_in) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      freq_out <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      freq_out <= freq_d;
      tick     <= tick_d;
    end
  end

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed bench: per-cycle vector table for the divider, plus a full-range
// period measurement at N = 2^16-1.
module tb_prog_freq_divider;

  localparam int WIDTH = 16;

  logic             freq_in = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             div_load = 1'b0;
  logic             freq_out, tick, div_pending, div_err;

  int passed = 0;
  int total  = 0;

  prog_freq_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
    .freq_in    (freq_in),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .freq_out   (freq_out),
    .tick       (tick),
    .div_pending(div_pending),
    .div_err    (div_err)
  );

  always #5 freq_in = ~freq_in;

  typedef struct {
    logic             r, e, l;
    logic [WIDTH-1:0] d;
    logic [3:0]       exp;  // {freq_out, tick, div_pending, div_err}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic e, logic l, int d,
                             logic fo, logic tk, logic pd, logic er);
    vec_t x;
    x.r = r; x.e = e; x.l = l; x.d = WIDTH'(d);
    x.exp = {fo, tk, pd, er};
    return x;
  endfunction

  task automatic step();
    @(posedge freq_in);
    #1;
  endtask

  task automatic check(string name, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  initial begin
    int n, hi;
    //             rst en ld din   fo tk pd er
    // reset overrides en/load; default period 4 -> 1,1,0,0
    vecs.push_back(v(1, 1, 1, 9,    0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 0, 0));
    // load 5 mid-period: old period finishes, then high 2 / low 3
    vecs.push_back(v(0, 1, 1, 5,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    // load 0 and 1: both clamp to 2, two err pulses, then 1,0 toggling
    vecs.push_back(v(0, 1, 1, 0,    1, 0, 1, 1));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 1, 1,    0, 0, 1, 1));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    // load 7 then 9 in one period: 9 wins (period 9, high 4)
    vecs.push_back(v(0, 1, 1, 7,    1, 1, 1, 0));
    vecs.push_back(v(0, 1, 1, 9,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    // load 4, then load 3 on the wrap edge: 4 applies now, 3 at next wrap
    vecs.push_back(v(0, 1, 1, 4,    1, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 1, 3,    1, 1, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    // stop 3 cycles mid-period; a load while idle applies on the next edge
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 2,    0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    // reset with load 6 pending: discarded, period back to 4
    vecs.push_back(v(0, 1, 1, 6,    0, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0,    1, 1, 0, 0));

    foreach (vecs[i]) begin
      rst = vecs[i].r; en = vecs[i].e; div_load = vecs[i].l; div_in = vecs[i].d;
      step();
      check($sformatf("vec%0d {fo,tk,pd,er}", i),
            int'({freq_out, tick, div_pending, div_err}), int'(vecs[i].exp));
    end

    // Largest divisor: period 65535, high 32767, no overflow.
    div_load = 1'b1; div_in = 16'hFFFF;
    step();
    div_load = 1'b0;
    check("max pending", int'(div_pending), 1);
    n = 0;
    while (!tick && n < 10) begin step(); n++; end
    check("max apply tick", int'(tick), 1);
    check("max pending cleared", int'(div_pending), 0);
    n = 0; hi = 0;
    do begin
      if (freq_out) hi++;
      step();
      n++;
    end while (!tick && n < 70000);
    check("max period", n, 65535);
    check("max high", hi, 32767);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
